add_seq_ctrl: RTL and testbench

Sequencing controller that performs multi-nibble add/subtract operations on one shared 4-bit ripple adder slice, one nibble per clock, LSB first. Two clients share the block through a round-robin request/acknowledge handshake. Results, carry-out and signed overflow are reported with a one-cycle done pulse. The block sits between client logic and the 4-bit adder datapath, so wide arithmetic needs no wide adder.

---
 rtl/add_seq_pkg.sv | 14 +
 rtl/add_seq_ctrl_nibble_adder.sv | 25 ++
 rtl/add_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_add_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam int   NIBBLE_W = 4;

endpackage

// File: rtl/add_seq_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice shared by every nibble step.
module nibble_adder
   import add_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W:0] c;

   always_comb begin
      c[0] = cin;
      s    = '0;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Round-robin shared sequencer that runs W-bit add/subtract one nibble per
// clock through a single 4-bit adder slice, LSB first.
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0,
   input  logic                     req1,
   input  logic                     op0,
   input  logic                     op1,
   input  logic [NIBBLE_W*NIBBLES-1:0] a0,
   input  logic [NIBBLE_W*NIBBLES-1:0] b0,
   input  logic [NIBBLE_W*NIBBLES-1:0] a1,
   input  logic [NIBBLE_W*NIBBLES-1:0] b1,
   output logic                     ack0,
   output logic                     ack1,
   output logic                     busy,
   output logic                     done,
   output logic                     done_id,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                     cout,
   output logic                     ovf
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t             state, state_next;
   logic [IDX_W-1:0]   idx, idx_next;
   logic [W-1:0]       a_reg, a_next;
   logic [W-1:0]       b_reg, b_next;
   logic               carry, carry_next;
   logic               gnt, gnt_next;
   logic               last_gnt, last_gnt_next;
   logic [W-1:0]       sum_next;
   logic               cout_next, ovf_next;
   logic               done_next, done_id_next;
   logic               ack0_next, ack1_next;
   logic               busy_next;

   logic               grant;
   logic               op_sel;
   logic [W-1:0]       a_sel, b_sel;
   logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
   logic               slice_cout;

   // Contention goes to whichever client did not win last time.
   assign grant  = (req0 && req1) ? ~last_gnt : req1;
   assign op_sel = grant ? op1 : op0;
   assign a_sel  = grant ? a1 : a0;
   assign b_sel  = grant ? b1 : b0;

   assign slice_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
   assign slice_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];

   nibble_adder u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_comb begin
      state_next    = state;
      idx_next      = idx;
      a_next        = a_reg;
      b_next        = b_reg;
      carry_next    = carry;
      gnt_next      = gnt;
      last_gnt_next = last_gnt;
      sum_next      = sum;
      cout_next     = cout;
      ovf_next      = ovf;
      done_next     = 1'b0;
      done_id_next  = done_id;
      ack0_next     = 1'b0;
      ack1_next     = 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_next    = RUN;
               idx_next      = '0;
               gnt_next      = grant;
               last_gnt_next = grant;
               a_next        = a_sel;
               // Subtract is A + ~B + 1; the +1 enters as the initial carry.
               b_next        = (op_sel == OP_SUB) ? ~b_sel : b_sel;
               carry_next    = op_sel;
               ack0_next     = ~grant;
               ack1_next     = grant;
            end
         end
         RUN: begin
            sum_next[idx*NIBBLE_W +: NIBBLE_W] = slice_s;
            carry_next = slice_cout;
            if (idx == LAST_IDX) begin
               state_next   = DONE;
               cout_next    = slice_cout;
               ovf_next     = (a_reg[W-1] == b_reg[W-1]) &&
                              (slice_s[NIBBLE_W-1] != a_reg[W-1]);
               done_next    = 1'b1;
               done_id_next = gnt;
            end else begin
               idx_next = idx + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         done_id  <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         idx      <= idx_next;
         a_reg    <= a_next;
         b_reg    <= b_next;
         carry    <= carry_next;
         gnt      <= gnt_next;
         last_gnt <= last_gnt_next;
         sum      <= sum_next;
         cout     <= cout_next;
         ovf      <= ovf_next;
         done     <= done_next;
         done_id  <= done_id_next;
         ack0     <= ack0_next;
         ack1     <= ack1_next;
         busy     <= busy_next;
      end
   end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl against a plain-arithmetic
// reference model with a round-robin grant tracker.
module tb_add_seq_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, op0, op1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         ack0, ack1, busy, done, done_id, cout, ovf;
   logic [W-1:0] sum;

   int vectors     = 0;
   int miscompares = 0;
   bit model_last  = 1'b1;

   add_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .req1    (req1),
      .op0     (op0),
      .op1     (op1),
      .a0      (a0),
      .b0      (b0),
      .a1      (a1),
      .b1      (b1),
      .ack0    (ack0),
      .ack1    (ack1),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .sum     (sum),
      .cout    (cout),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected result from signed/unsigned integer arithmetic on whole operands.
   function automatic void refModel(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output bit c, output bit v);
      longint ua, ub, sa, sb, r, smax, smin;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      s    = op ? a - b : a + b;
      c    = op ? (ua >= ub) : (((ua + ub) >> W) != 0);
      r    = op ? sa - sb : sa + sb;
      v    = (r > smax) || (r < smin);
   endfunction

   task automatic setClient(input bit client, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (client) begin op1 = op; a1 = a; b1 = b; end
      else        begin op0 = op; a0 = a; b0 = b; end
   endtask

   task automatic setReq(input bit client, input bit v);
      if (client) req1 = v;
      else        req0 = v;
   endtask

   task automatic scramble(input bit client);
      setClient(client, 1'($urandom), W'($urandom), W'($urandom));
   endtask

   task automatic waitAck(input bit client, output int cycles);
      bit seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < 12) begin
         @(posedge clk); #1;
         cycles++;
         if (client ? ack1 : ack0) seen = 1'b1;
      end
      checkOutput("ack_seen", 32'(seen), 1);
      checkOutput("ack_other", 32'(client ? ack0 : ack1), 0);
   endtask

   // Called one step after the accept edge; optional chain raises a request during DONE.
   task automatic waitResult(input bit client, input bit op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input int chain);
      logic [W-1:0] es;
      bit ec, ev, seen;
      int cycles;
      refModel(op, a, b, es, ec, ev);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
         if (done) seen = 1'b1;
      end
      checkOutput("done_seen", 32'(seen), 1);
      if (!seen) return;
      checkOutput("latency", 32'(cycles), NIBBLES);
      checkOutput("done_id", 32'(done_id), 32'(client));
      checkOutput("sum", 32'(sum), 32'(es));
      checkOutput("cout", 32'(cout), 32'(ec));
      checkOutput("ovf", 32'(ovf), 32'(ev));
      if (chain >= 0) setReq(chain[0], 1'b1);
      @(posedge clk); #1;
      checkOutput("done_pulse_width", 32'(done), 0);
      checkOutput("busy_after_done", 32'(busy), 0);
      checkOutput("no_ack_in_done", 32'({ack1, ack0}), 0);
      checkOutput("sum_held", 32'(sum), 32'(es));
   endtask

   task automatic applyStimulus(input bit client, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      setClient(client, op, a, b);
      setReq(client, 1'b1);
      waitAck(client, n);
      checkOutput("ack_delay", 32'(n), 1);
      checkOutput("busy_on_accept", 32'(busy), 1);
      model_last = client;
      setReq(client, 1'b0);
      scramble(client);
      waitResult(client, op, a, b, -1);
   endtask

   task automatic pairTest();
      bit           op [2];
      logic [W-1:0] a [2];
      logic [W-1:0] b [2];
      bit           first, second, seen;
      int           n;
      for (int c = 0; c < 2; c++) begin
         op[c] = 1'($urandom);
         a[c]  = W'($urandom);
         b[c]  = W'($urandom);
         setClient(c[0], op[c], a[c], b[c]);
      end
      first  = ~model_last;
      second = model_last;
      req0 = 1'b1;
      req1 = 1'b1;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < 12) begin
         @(posedge clk); #1;
         n++;
         if (ack0 || ack1) seen = 1'b1;
      end
      checkOutput("pair_first_ack", 32'({ack1, ack0}), first ? 32'h2 : 32'h1);
      model_last = first;
      setReq(first, 1'b0);
      scramble(first);
      waitResult(first, op[first], a[first], b[first], -1);
      waitAck(second, n);
      checkOutput("pair_second_delay", 32'(n), 1);
      model_last = second;
      setReq(second, 1'b0);
      scramble(second);
      waitResult(second, op[second], a[second], b[second], -1);
   endtask

   task automatic resetMidRun();
      int n;
      bit saw_done = 1'b0;
      setClient(1'b1, 1'b0, 16'h5A5A, 16'h1111);
      setReq(1'b1, 1'b1);
      waitAck(1'b1, n);
      setReq(1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_ctrl", 32'({busy, done, ack0, ack1, done_id}), 0);
      checkOutput("rst_result", 32'({cout, ovf, sum}), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      checkOutput("no_done_after_abort", 32'(saw_done), 0);
      model_last = 1'b1;
      pairTest();
   endtask

   task automatic doneRequest();
      int n;
      setClient(1'b0, 1'b0, 16'h0F0F, 16'h0101);
      setClient(1'b1, 1'b1, 16'h0003, 16'h0009);
      setReq(1'b0, 1'b1);
      waitAck(1'b0, n);
      model_last = 1'b0;
      setReq(1'b0, 1'b0);
      waitResult(1'b0, 1'b0, 16'h0F0F, 16'h0101, 1);
      waitAck(1'b1, n);
      checkOutput("done_req_delay", 32'(n), 1);
      model_last = 1'b1;
      setReq(1'b1, 1'b0);
      waitResult(1'b1, 1'b1, 16'h0003, 16'h0009, -1);
   endtask

   initial begin
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      op0   = 1'b0;
      op1   = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      #12;
      checkOutput("reset_state", 32'({busy, done, ack0, ack1, done_id, cout, ovf}), 0);
      checkOutput("reset_sum", 32'(sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b0, 1'b0, 16'h1234, 16'h0FCD);
      applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0001);
      applyStimulus(1'b1, 1'b0, 16'h7FFF, 16'h0001);
      applyStimulus(1'b0, 1'b1, 16'h0005, 16'h0007);
      applyStimulus(1'b1, 1'b1, 16'h8000, 16'h0001);
      applyStimulus(1'b0, 1'b1, 16'h1234, 16'h0000);

      model_last = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
      pairTest();
      pairTest();

      resetMidRun();
      doneRequest();

      for (int i = 0; i < 24; i++) begin
         if ((i % 4) == 3) pairTest();
         else applyStimulus(1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

endmodule
